// File: rtl/sfp_pkg.sv
// sfp_pkg: shared sizes, saturation bounds and FSM encoding for the sfp accumulate stage
package sfp_pkg;
  localparam int PSUM_BW = 16;
  localparam int COL = 8;
  localparam int ADDR_BW = 11;
  localparam int PSUM_MAX = 32767;
  localparam int PSUM_MIN = -32768;
  typedef enum logic [2:0] {IDLE, WAIT, READ, ADD, WRITE, DONE} state_t;
endpackage

// File: rtl/sfp_accum_if.sv
// sfp_accum_if: OFIFO pop path and psum SRAM port seen by the accumulate stage
interface sfp_accum_if import sfp_pkg::*; #(
  parameter int psum_bw = PSUM_BW,
  parameter int col = COL,
  parameter int addr_bw = ADDR_BW
);
  logic ofifo_valid;
  logic ofifo_rd;
  logic [psum_bw*col-1:0] ofifo_out;
  logic [psum_bw*col-1:0] sram_p;
  logic CEN_pmem;
  logic WEN_pmem;
  logic [addr_bw-1:0] A_pmem;
  logic [psum_bw*col-1:0] sfp_out;
  modport master (
    input ofifo_valid, ofifo_out, sram_p,
    output ofifo_rd, CEN_pmem, WEN_pmem, A_pmem, sfp_out
  );
  modport slave (
    output ofifo_valid, ofifo_out, sram_p,
    input ofifo_rd, CEN_pmem, WEN_pmem, A_pmem, sfp_out
  );
endinterface

// File: rtl/sfp_lane.sv
// sfp_lane: one column's saturating psum + ofifo add with optional ReLU
module sfp_lane import sfp_pkg::*; #(
  parameter int psum_bw = PSUM_BW
) (
  input  logic [psum_bw-1:0] psum,
  input  logic [psum_bw-1:0] ofifo,
  input  logic               first_pass,
  input  logic               relu_en,
  output logic [psum_bw-1:0] sum
);
  logic [psum_bw:0] s;
  logic [psum_bw-1:0] c;
  always_comb begin
    s = {ofifo[psum_bw-1], ofifo} + (first_pass ? '0 : {psum[psum_bw-1], psum});
    c = s[psum_bw] != s[psum_bw-1] ? (s[psum_bw] ? psum_bw'(PSUM_MIN) : psum_bw'(PSUM_MAX)) : s[psum_bw-1:0];
    sum = relu_en && c[psum_bw-1] ? '0 : c;
  end
endmodule

// File: rtl/sfp_accum.sv
// sfp_accum: OFIFO-row read-modify-write accumulate into the psum SRAM
module sfp_accum import sfp_pkg::*; #(
  parameter int psum_bw = PSUM_BW,
  parameter int col = COL,
  parameter int addr_bw = ADDR_BW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [addr_bw-1:0] len,
  input  logic               first_pass,
  input  logic               relu_en,
  sfp_accum_if.master        bus,
  output logic               busy,
  output logic               done
);
  state_t state_q, state_d;
  logic [addr_bw-1:0] cnt_q, cnt_d, base_q, base_d, len_q, len_d, a_q, a_d;
  logic first_q, first_d, relu_q, relu_d, rd_q, rd_d, cen_q, cen_d, wen_q, wen_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [psum_bw*col-1:0] sfp_q, sfp_d, lane_sum;
  for (genvar i = 0; i < col; i++) begin : g_lane
    sfp_lane #(.psum_bw(psum_bw)) u_lane (
      .psum(bus.sram_p[psum_bw*i +: psum_bw]),
      .ofifo(bus.ofifo_out[psum_bw*i +: psum_bw]),
      .first_pass(first_q),
      .relu_en(relu_q),
      .sum(lane_sum[psum_bw*i +: psum_bw])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    len_d = len_q;
    first_d = first_q;
    relu_d = relu_q;
    sfp_d = sfp_q;
    unique case (state_q)
      IDLE: if (start) begin
        base_d = base_addr;
        len_d = len;
        first_d = first_pass;
        relu_d = relu_en;
        state_d = len == '0 ? DONE : WAIT;
      end
      WAIT: state_d = bus.ofifo_valid ? READ : WAIT;
      READ: state_d = ADD;
      ADD: begin
        sfp_d = lane_sum;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_d == len_q ? DONE : WAIT;
      end
      DONE: begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    rd_d = state_d == READ;
    cen_d = !(state_d == READ || state_d == WRITE);
    wen_d = state_d != WRITE;
    a_d = cen_d ? a_q : base_q + cnt_q;
    busy_d = state_d != IDLE;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      len_q <= '0;
      first_q <= 1'b0;
      relu_q <= 1'b0;
      sfp_q <= '0;
      rd_q <= 1'b0;
      cen_q <= 1'b1;
      wen_q <= 1'b1;
      a_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      len_q <= len_d;
      first_q <= first_d;
      relu_q <= relu_d;
      sfp_q <= sfp_d;
      rd_q <= rd_d;
      cen_q <= cen_d;
      wen_q <= wen_d;
      a_q <= a_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.ofifo_rd = rd_q;
  assign bus.CEN_pmem = cen_q;
  assign bus.WEN_pmem = wen_q;
  assign bus.A_pmem = a_q;
  assign bus.sfp_out = sfp_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum: randomized runs against an integer-arithmetic accumulate model
module tb_sfp_accum;
  typedef struct {logic [10:0] a; logic [127:0] d;} wr_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, first_pass = 1'b0, relu_en = 1'b0;
  logic [10:0] base_addr = '0, len = '0;
  logic busy, done;
  logic gate = 1'b1, last_valid = 1'b0, pk = 1'b0;
  logic [10:0] pk_a = '0;
  logic [127:0] pk_d = '0;
  logic [127:0] mem [2048];
  logic [127:0] ref_mem [2048];
  logic [127:0] fifo [$];
  logic [127:0] rows_in [$];
  wr_t exp_q [$];
  int checks = 0, failures = 0, cyc = 0, rd_cyc = 0, done_cyc = 0, nr = 0, nw = 0;

  sfp_accum_if #(.psum_bw(16), .col(8), .addr_bw(11)) bus ();
  sfp_accum dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .first_pass(first_pass), .relu_en(relu_en), .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] p, input logic [127:0] r, input bit fp, input bit re);
    logic [127:0] m;
    int s;
    for (int i = 0; i < 8; i++) begin
      s = (fp ? 0 : int'($signed(p[16*i +: 16]))) + int'($signed(r[16*i +: 16]));
      s = s > 32767 ? 32767 : (s < -32768 ? -32768 : s);
      if (re && s < 0) s = 0;
      m[16*i +: 16] = 16'(s);
    end
    return m;
  endfunction

  function automatic logic [127:0] rnd_row();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0: r[16*i +: 16] = 16'h7fff;
        1: r[16*i +: 16] = 16'h8000;
        default: r[16*i +: 16] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  // SRAM and OFIFO environment models
  always @(posedge clk) begin
    if (pk) mem[pk_a] <= pk_d;
    else if (!bus.CEN_pmem) begin
      if (!bus.WEN_pmem) mem[bus.A_pmem] <= bus.sfp_out;
      else bus.sram_p <= mem[bus.A_pmem];
    end
    if (bus.ofifo_rd && fifo.size() != 0) bus.ofifo_out <= fifo.pop_front();
  end

  always @(negedge clk) begin
    wr_t e;
    cyc++;
    if (reset) begin
      if (bus.ofifo_rd) rd_cyc = cyc;
      if (done) done_cyc = cyc;
      chk("rd_with_read", bus.ofifo_rd, !bus.CEN_pmem && bus.WEN_pmem);
      if (bus.ofifo_rd) chk("rd_after_valid", last_valid, 1);
      if (!bus.CEN_pmem && bus.WEN_pmem) begin
        nr++;
        if (exp_q.size() != 0) chk("read_addr", bus.A_pmem, exp_q[0].a);
      end
      if (!bus.CEN_pmem && !bus.WEN_pmem) begin
        nw++;
        chk("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("write_addr", bus.A_pmem, e.a);
          chk("write_data", bus.sfp_out, e.d);
          ref_mem[e.a] = e.d;
        end
      end
      if (done) chk("done_all_written", exp_q.size(), 0);
    end
    bus.ofifo_valid = gate && fifo.size() != 0;
    last_valid = bus.ofifo_valid;
  end

  task automatic poke(input int a, input logic [127:0] d);
    pk_a = 11'(a);
    pk_d = d;
    pk = 1'b1;
    @(negedge clk);
    pk = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic pulse_start(input int base, input int n, input bit fp, input bit re);
    base_addr = 11'(base);
    len = 11'(n);
    first_pass = fp;
    relu_en = re;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input int base, input int n, input bit fp, input bit re, input int gap, input bit pre);
    logic [127:0] rq [$];
    logic [127:0] row;
    int a, t;
    for (int k = 0; k < n; k++) begin
      a = (base + k) % 2048;
      if (pre) poke(a, rnd_row());
      row = rows_in.size() != 0 ? rows_in.pop_front() : rnd_row();
      exp_q.push_back('{11'(a), model(ref_mem[a], row, fp, re)});
      rq.push_back(row);
    end
    pulse_start(base, n, fp, re);
    chk("busy_after_start", busy, 1);
    if (n == 0) chk("len0_done_next", done, 1);
    for (int k = 0; k < n; k++) begin
      fifo.push_back(rq[k]);
      if (gap > 0 && k < n - 1) begin
        t = 0;
        while (fifo.size() != 0 && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("row_popped", fifo.size(), 0);
        repeat (gap) @(negedge clk);
      end
    end
    t = 0;
    while (!done && t < n * (gap + 10) + 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    int lv[8], ev[8];
    logic [127:0] r, x;
    int w0, r0;
    repeat (3) @(negedge clk);
    chk("rst_rd", bus.ofifo_rd, 0);
    chk("rst_cen", bus.CEN_pmem, 1);
    chk("rst_wen", bus.WEN_pmem, 1);
    chk("rst_a", bus.A_pmem, 0);
    chk("rst_sfp", bus.sfp_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clk);

    poke(5, {8{16'd10}});
    rows_in.push_back({8{16'd3}});
    run(5, 1, 0, 0, 0, 0);
    chk("basic_mem", mem[5], {8{16'd13}});
    chk("basic_done_latency", done_cyc - rd_cyc, 3);

    lv = '{-4, 7, 0, -1, 2, -32768, 32767, 5};
    ev = '{0, 7, 0, 0, 2, 0, 32767, 5};
    for (int i = 0; i < 8; i++) begin
      r[16*i +: 16] = 16'(lv[i]);
      x[16*i +: 16] = 16'(ev[i]);
    end
    poke(20, rnd_row());
    rows_in.push_back(r);
    run(20, 1, 1, 1, 0, 0);
    chk("relu_mem", mem[20], x);

    poke(30, {{6{16'd0}}, 16'(-32760), 16'd32760});
    rows_in.push_back({{6{16'd1}}, 16'(-100), 16'd100});
    run(30, 1, 0, 0, 0, 0);
    chk("sat_mem", mem[30], {{6{16'd1}}, 16'h8000, 16'h7fff});

    w0 = nw;
    run(40, 3, 0, 0, 5, 1);
    chk("bp_write_count", nw - w0, 3);

    w0 = nw;
    run(2047, 2, 0, 1, 0, 1);
    chk("wrap_write_count", nw - w0, 2);
    w0 = nw;
    r0 = nr;
    run(7, 0, 0, 0, 0, 0);
    chk("len0_no_writes", nw - w0, 0);
    chk("len0_no_reads", nr - r0, 0);

    poke(100, rnd_row());
    x = ref_mem[100];
    pulse_start(100, 2, 0, 0);
    fifo.push_back(rnd_row());
    fifo.push_back(rnd_row());
    w0 = 0;
    while (!bus.ofifo_rd && w0 < 20) begin
      @(negedge clk);
      w0++;
    end
    chk("rstmid_read_seen", bus.ofifo_rd, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rd", bus.ofifo_rd, 0);
    chk("rstmid_cen", bus.CEN_pmem, 1);
    chk("rstmid_wen", bus.WEN_pmem, 1);
    chk("rstmid_a", bus.A_pmem, 0);
    chk("rstmid_sfp", bus.sfp_out, 0);
    chk("rstmid_busy", busy, 0);
    @(negedge clk);
    chk("rstmid_no_write", mem[100], x);
    reset = 1'b1;
    fifo.delete();
    exp_q.delete();
    @(negedge clk);
    poke(5, {8{16'd10}});
    rows_in.push_back({8{16'd3}});
    run(5, 1, 0, 0, 0, 0);
    chk("post_rst_basic_mem", mem[5], {8{16'd13}});

    for (int k = 0; k < 12; k++)
      run($urandom_range(0, 2047), $urandom_range(1, 6), 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
